// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, instruction IDs,
// per-instruction cycle counts, FSM state encoding and the decoder result type.
package instruction_sequencer_pkg;

    localparam int WORD_W = 16;
    localparam int ID_W   = 8;
    localparam int CNT_W  = 2;

    localparam logic [ID_W-1:0] ID_NOP     = 8'h00;
    localparam logic [ID_W-1:0] ID_LPM     = 8'h22;
    localparam logic [ID_W-1:0] ID_RJMP    = 8'h30;
    localparam logic [ID_W-1:0] ID_RET     = 8'h31;
    localparam logic [ID_W-1:0] ID_JMP     = 8'h40;
    localparam logic [ID_W-1:0] ID_CALL    = 8'h41;
    localparam logic [ID_W-1:0] ID_UNKNOWN = 8'hFF;

    // Stored as cycles-1 so the counter compares directly against it.
    localparam logic [CNT_W-1:0] LAST_NOP     = 2'd0;
    localparam logic [CNT_W-1:0] LAST_LPM     = 2'd2;
    localparam logic [CNT_W-1:0] LAST_RJMP    = 2'd1;
    localparam logic [CNT_W-1:0] LAST_RET     = 2'd3;
    localparam logic [CNT_W-1:0] LAST_JMP     = 2'd2;
    localparam logic [CNT_W-1:0] LAST_CALL    = 2'd3;
    localparam logic [CNT_W-1:0] LAST_UNKNOWN = 2'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPND = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] last_cnt;
        logic             two_word;
    } decode_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Fetch-side handshake plus execution-side outputs of the instruction sequencer.
interface instruction_sequencer_if;
    import instruction_sequencer_pkg::*;

    logic [WORD_W-1:0] instr_word;
    logic              instr_valid;
    logic              instr_ready;
    logic              flush;
    logic [ID_W-1:0]   instruction_id;
    logic [CNT_W-1:0]  clock_counter;
    logic [WORD_W-1:0] operand_word;
    logic              instr_last;

    modport master (
        output instr_word, instr_valid, flush,
        input  instr_ready, instruction_id, clock_counter, operand_word, instr_last
    );

    modport slave (
        input  instr_word, instr_valid, flush,
        output instr_ready, instruction_id, clock_counter, operand_word, instr_last
    );

endinterface

// File: rtl/instruction_sequencer_decode.sv
// Combinational decoder: program word -> instruction ID, last cycle index and
// two-word flag.
module instruction_sequencer_decode
    import instruction_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] instr_word,
    output decode_t           dec
);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves dec unassigned, which would infer a latch.
        dec = '{id: ID_UNKNOWN, last_cnt: LAST_UNKNOWN, two_word: 1'b0};
        if (instr_word == 16'h0000) begin
            dec = '{id: ID_NOP, last_cnt: LAST_NOP, two_word: 1'b0};
        end else if (instr_word == 16'h9508) begin
            dec = '{id: ID_RET, last_cnt: LAST_RET, two_word: 1'b0};
        end else if (instr_word == 16'h95C8 || (instr_word & 16'hFE0E) == 16'h9004) begin
            dec = '{id: ID_LPM, last_cnt: LAST_LPM, two_word: 1'b0};
        end else if (instr_word[15:12] == 4'hC) begin
            dec = '{id: ID_RJMP, last_cnt: LAST_RJMP, two_word: 1'b0};
        end else if ((instr_word & 16'hFE0E) == 16'h940C) begin
            dec = '{id: ID_JMP, last_cnt: LAST_JMP, two_word: 1'b1};
        end else if ((instr_word & 16'hFE0E) == 16'h940E) begin
            dec = '{id: ID_CALL, last_cnt: LAST_CALL, two_word: 1'b1};
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: accepts fetched words, tracks multi-cycle execution with
// a cycle counter, stalls fetch until the last cycle and captures operand words.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    instruction_sequencer_if.slave  bus
);

    state_e            state_q,    state_d;
    logic [ID_W-1:0]   id_q,       id_d;
    logic [ID_W-1:0]   held_id_q,  held_id_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  last_cnt_q, last_cnt_d;
    logic [WORD_W-1:0] opnd_q,     opnd_d;

    decode_t dec;
    logic    run_last;
    logic    ready;
    logic    accept;

    instruction_sequencer_decode u_decode (
        .instr_word (bus.instr_word),
        .dec        (dec)
    );

    // Handshake is derived only from registered state, never from instr_valid.
    assign run_last = (state_q == S_RUN) && (cnt_q == last_cnt_q);
    assign ready    = (state_q == S_IDLE) || (state_q == S_OPND) || run_last;
    assign accept   = bus.instr_valid && ready;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        held_id_d  = held_id_q;
        cnt_d      = cnt_q;
        last_cnt_d = last_cnt_q;
        opnd_d     = opnd_q;

        if (bus.flush) begin
            state_d    = S_IDLE;
            id_d       = ID_NOP;
            held_id_d  = ID_NOP;
            cnt_d      = '0;
            last_cnt_d = '0;
            opnd_d     = '0;
        end else begin
            case (state_q)
                S_OPND: begin
                    // The operand fetch is not counted; the counter starts with S_RUN.
                    if (bus.instr_valid) begin
                        state_d = S_RUN;
                        id_d    = held_id_q;
                        cnt_d   = '0;
                        opnd_d  = bus.instr_word;
                    end
                end
                default: begin
                    if (state_q == S_RUN && !run_last) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (accept && dec.two_word) begin
                        state_d    = S_OPND;
                        id_d       = ID_NOP;
                        held_id_d  = dec.id;
                        cnt_d      = '0;
                        last_cnt_d = dec.last_cnt;
                        opnd_d     = '0;
                    end else if (accept) begin
                        state_d    = S_RUN;
                        id_d       = dec.id;
                        cnt_d      = '0;
                        last_cnt_d = dec.last_cnt;
                        opnd_d     = '0;
                    end else begin
                        state_d    = S_IDLE;
                        id_d       = ID_NOP;
                        cnt_d      = '0;
                        last_cnt_d = '0;
                        opnd_d     = '0;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            id_q       <= ID_NOP;
            held_id_q  <= ID_NOP;
            cnt_q      <= '0;
            last_cnt_q <= '0;
            opnd_q     <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            held_id_q  <= held_id_d;
            cnt_q      <= cnt_d;
            last_cnt_q <= last_cnt_d;
            opnd_q     <= opnd_d;
        end
    end

    assign bus.instr_ready    = ready;
    assign bus.instr_last     = run_last || (state_q == S_IDLE);
    assign bus.instruction_id = id_q;
    assign bus.clock_counter  = cnt_q;
    assign bus.operand_word   = opnd_q;

endmodule
